// File: rtl/countdown_timer.sv
// countdown_timer
//   Minutes:seconds countdown timer. A prescaler divides clk down to a
//   one-second tick that runs only while counting; the count decrements once
//   per tick and the block flags expiry with a one-cycle done pulse.
//
//   Optional feature (compile-time macro COUNTDOWN_TIMER_ALARM_EN):
//     adds a sticky alarm output that sets together with done and clears on
//     alarm_ack, load or reset.
//
// Parameters
//   TICK_DIV  clk cycles per one-second tick (>= 2)
//   MAX_MIN   largest loadable minutes value (1..63)
//
// Ports
//   clk        in   clock, all state updates on rising edge
//   rst        in   asynchronous reset, active low
//   load       in   load load_min/load_sec (clamped), go to IDLE
//   load_min   in   minutes preset
//   load_sec   in   seconds preset
//   start      in   start from IDLE (nonzero count) or resume from PAUSE
//   pause      in   suspend counting while running
//   min        out  current minutes (registered)
//   sec        out  current seconds (registered)
//   running    out  high while counting
//   done       out  one-cycle pulse after the count reaches 00:00
//   alarm      out  (ALARM_EN only) sticky expiry flag
//   alarm_ack  in   (ALARM_EN only) clears alarm
module countdown_timer #(
    parameter int TICK_DIV = 1000,
    parameter int MAX_MIN  = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [5:0] load_min,
    input  logic [5:0] load_sec,
    input  logic       start,
    input  logic       pause,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       running,
`ifdef COUNTDOWN_TIMER_ALARM_EN
    output logic       alarm,
    input  logic       alarm_ack,
`endif
    output logic       done
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [5:0]    MIN_CAP    = 6'(MAX_MIN);
    localparam logic [5:0]    SEC_CAP    = 6'd59;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          done_q;
    logic          tick;
    logic          expire;
    logic          count_zero;

    assign tick       = (state_q == RUN) && (presc_q == PRESC_LAST);
    assign count_zero = (min_q == 6'd0) && (sec_q == 6'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            min_q   <= 6'd0;
            sec_q   <= 6'd0;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            presc_q <= presc_d;
            done_q  <= expire;
        end
    end

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        presc_d = presc_q;
        expire  = 1'b0;

        if (load) begin
            // load overrides every other input in every state
            state_d = IDLE;
            min_d   = (load_min > MIN_CAP) ? MIN_CAP : load_min;
            sec_d   = (load_sec > SEC_CAP) ? SEC_CAP : load_sec;
            presc_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // a zero count never starts, so done cannot fire from IDLE
                    if (start && !count_zero) state_d = RUN;
                end
                RUN: begin
                    if (tick) begin
                        presc_d = '0;
                        if (sec_q != 6'd0) begin
                            sec_d = sec_q - 6'd1;
                        end else if (min_q != 6'd0) begin
                            sec_d = SEC_CAP;
                            min_d = min_q - 6'd1;
                        end
                        // expiry outranks a coincident pause
                        if ((min_d == 6'd0) && (sec_d == 6'd0)) begin
                            state_d = DONE;
                            expire  = 1'b1;
                        end else if (pause) begin
                            state_d = PAUSE;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                        if (pause) state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    // prescaler is held here so resume keeps sub-second phase
                    if (start) state_d = RUN;
                end
                DONE: begin
                    state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef COUNTDOWN_TIMER_ALARM_EN
    logic alarm_q;

    // set beats ack so an ack in the expiry cycle is ignored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           alarm_q <= 1'b0;
        else if (load)      alarm_q <= 1'b0;
        else if (expire)    alarm_q <= 1'b1;
        else if (alarm_ack) alarm_q <= 1'b0;
    end

    assign alarm = alarm_q;
`endif

    assign min     = min_q;
    assign sec     = sec_q;
    assign running = (state_q == RUN);
    assign done    = done_q;

endmodule
